// File: rtl/cam_dvp_tx.sv
// DVP camera-style transmitter: frame timing FSM plus synthetic RGB565 test patterns.
// Each byte slot is two clk cycles (pclk low then high); outputs change only at slot start.
module cam_dvp_tx #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned L         = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned ACT_BYTES = 2 * H_ACTIVE;
  localparam int unsigned BAR_W     = H_ACTIVE / 8;
  localparam int unsigned COL_W     = $clog2(L + 1);
  localparam int unsigned X_W       = $clog2(H_ACTIVE);
  localparam int unsigned LINE_W    = 16;

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t             state;
  logic               phase;
  logic [COL_W-1:0]   col;
  logic [LINE_W-1:0]  line;
  logic [X_W-1:0]     x;
  logic [X_W-1:0]     bar_cnt;
  logic [2:0]         bar;
  logic               low_byte;
  logic [7:0]         n;
  logic [1:0]         pat;
  logic [15:0]        solid;

  state_t             nstate_c;
  logic [COL_W-1:0]   ncol_c;
  logic [LINE_W-1:0]  nline_c;
  logic [LINE_W-1:0]  last_line_c;
  logic               line_end_c;
  logic               period_end_c;
  logic               frame_end_c;
  logic               start_c;
  logic               href_c;
  logic [15:0]        bar_rgb_c;
  logic [15:0]        pixel_c;
  logic [7:0]         byte_c;

  // Position of the slot that begins at the next slot-start edge.
  always_comb begin
    nstate_c     = state;
    ncol_c       = col + COL_W'(1);
    nline_c      = line;
    last_line_c  = '0;
    case (state)
      VSYNC:   last_line_c = LINE_W'(VSYNC_LINES - 1);
      VBACK:   last_line_c = LINE_W'(V_BACK - 1);
      ACTIVE:  last_line_c = LINE_W'(V_ACTIVE - 1);
      VFRONT:  last_line_c = LINE_W'(V_FRONT - 1);
      default: last_line_c = '0;
    endcase
    line_end_c   = (col == COL_W'(L - 1));
    period_end_c = line_end_c && (line == last_line_c);
    frame_end_c  = (state == VFRONT) && period_end_c;
    if (line_end_c) begin
      ncol_c  = '0;
      nline_c = line + LINE_W'(1);
    end
    if (state == IDLE) begin
      ncol_c  = '0;
      nline_c = '0;
      if (enable) nstate_c = VSYNC;
    end else if (period_end_c) begin
      nline_c = '0;
      case (state)
        VSYNC:   nstate_c = VBACK;
        VBACK:   nstate_c = ACTIVE;
        ACTIVE:  nstate_c = VFRONT;
        default: nstate_c = enable ? VSYNC : IDLE;
      endcase
    end
    start_c = (nstate_c == VSYNC) && ((state == IDLE) || (state == VFRONT));
    href_c  = (nstate_c == ACTIVE) && (ncol_c < COL_W'(ACT_BYTES));
  end

  // Colour of the pixel currently pointed at by x / bar.
  always_comb begin
    bar_rgb_c = 16'h0000;
    case (bar)
      3'd0:    bar_rgb_c = 16'hFFFF;
      3'd1:    bar_rgb_c = 16'hFFE0;
      3'd2:    bar_rgb_c = 16'h07FF;
      3'd3:    bar_rgb_c = 16'h07E0;
      3'd4:    bar_rgb_c = 16'hF81F;
      3'd5:    bar_rgb_c = 16'hF800;
      3'd6:    bar_rgb_c = 16'h001F;
      default: bar_rgb_c = 16'h0000;
    endcase
    pixel_c = 16'h0000;
    case (pat)
      2'd0:    pixel_c = bar_rgb_c;
      2'd1:    pixel_c = 16'(x);
      2'd2:    pixel_c = solid;
      default: pixel_c = {8'h00, n};
    endcase
    byte_c = (pat == 2'd3) ? n : (low_byte ? pixel_c[7:0] : pixel_c[15:8]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= 1'b0;
      col        <= '0;
      line       <= '0;
      x          <= '0;
      bar_cnt    <= '0;
      bar        <= '0;
      low_byte   <= 1'b0;
      n          <= '0;
      pat        <= '0;
      solid      <= '0;
      cam_pclk   <= 1'b0;
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!phase) begin
        // Slot start: pclk falls and every slot-level output is updated.
        phase     <= 1'b1;
        cam_pclk  <= 1'b0;
        state     <= nstate_c;
        col       <= ncol_c;
        line      <= nline_c;
        cam_vsync <= (nstate_c == VSYNC);
        busy      <= (nstate_c != IDLE);
        cam_href  <= href_c;
        cam_data  <= href_c ? byte_c : 8'h00;
        if (start_c) begin
          pat      <= pattern_sel;
          solid    <= solid_color;
          n        <= '0;
          x        <= '0;
          bar      <= '0;
          bar_cnt  <= '0;
          low_byte <= 1'b0;
        end else if (href_c) begin
          n        <= n + 8'd1;
          low_byte <= ~low_byte;
          if (low_byte) begin
            if (x == X_W'(H_ACTIVE - 1)) begin
              x       <= '0;
              bar     <= '0;
              bar_cnt <= '0;
            end else begin
              x <= x + X_W'(1);
              if (bar_cnt == X_W'(BAR_W - 1)) begin
                bar_cnt <= '0;
                bar     <= bar + 3'd1;
              end else begin
                bar_cnt <= bar_cnt + X_W'(1);
              end
            end
          end
        end
      end else begin
        phase    <= 1'b0;
        cam_pclk <= 1'b1;
        if (frame_end_c) frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Randomized bench for cam_dvp_tx: three line widths run side by side against a
// frame-time reference model that derives every output from the cycle index within the frame.
module tb_cam_dvp_tx;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_color;
  logic [12:0] obs [3];
  bit          checking;
  int          n_cmp;
  int          n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bar_color(input int b);
    case (b)
      0:       return 16'hFFFF;
      1:       return 16'hFFE0;
      2:       return 16'h07FF;
      3:       return 16'h07E0;
      4:       return 16'hF81F;
      5:       return 16'hF800;
      6:       return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int HA = (g == 0) ? 8 : (g == 1) ? 16 : 64;
    localparam int LL = 2 * HA + 4;
    localparam int FR = 2 * LL * 7;

    logic        pclk, vsync, href, fdone, bsy;
    logic [7:0]  data;
    logic [12:0] expv;
    logic [1:0]  mp;
    logic [15:0] ms;
    logic [15:0] c16;
    logic [7:0]  d;
    logic        hr;
    bit          run;
    int          e, k, s, ln, c, al, x;

    cam_dvp_tx #(
      .H_ACTIVE(HA), .V_ACTIVE(4), .H_BLANK(4),
      .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .pattern_sel(pattern_sel), .solid_color(solid_color),
      .cam_pclk(pclk), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
      .frame_done(fdone), .busy(bsy)
    );

    assign obs[g] = {bsy, fdone, vsync, href, pclk, data};

    // Frame-time model: k is the clk index within the current frame.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        e    = 0;
        k    = 0;
        run  = 1'b0;
        expv = '0;
      end else begin
        if (run) begin
          k++;
          if (k == FR) begin
            run = 1'b0;
            if (enable) begin
              run = 1'b1; k = 0; mp = pattern_sel; ms = solid_color;
            end
          end
        end else if ((e % 2 == 0) && enable) begin
          run = 1'b1; k = 0; mp = pattern_sel; ms = solid_color;
        end
        if (run) begin
          s  = k / 2;
          ln = s / LL;
          c  = s % LL;
          al = ln - 2;
          x  = c / 2;
          hr = (ln >= 2) && (ln < 6) && (c < 2 * HA);
          case (mp)
            2'd0:    c16 = bar_color(x / (HA / 8));
            2'd1:    c16 = 16'(x);
            2'd2:    c16 = ms;
            default: c16 = {8'h00, 8'(al * 2 * HA + c)};
          endcase
          if (!hr)            d = 8'h00;
          else if (mp == 2'd3) d = c16[7:0];
          else if (c % 2 == 0) d = c16[15:8];
          else                d = c16[7:0];
          expv = {1'b1, (k == FR - 1), (ln < 1), hr, 1'(k % 2), d};
        end else begin
          expv = {4'b0000, 1'(e % 2), 8'h00};
        end
        e++;
      end
    end

    always @(negedge clk)
      if (checking) check($sformatf("out_h%0d", HA), 32'(obs[g]), 32'(expv));
  end

  task automatic do_reset(input bit en_after);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("async_rst%0d", i), 32'(obs[i]), 32'h0);
    enable = en_after;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] pats [6];
    pats[0] = 2'd3; pats[1] = 2'd0; pats[2] = 2'd2;
    pats[3] = 2'd1; pats[4] = 2'd3; pats[5] = 2'd0;
    n_cmp = 0;
    n_err = 0;
    checking = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    solid_color = 16'h0000;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("por_rst%0d", i), 32'(obs[i]), 32'h0);
    checking = 1'b1;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 6; p++) begin
      pattern_sel = pats[p];
      solid_color = 16'($urandom);
      if (p == 0) begin
        enable = 1'b1;
        reset = 1'b0;
      end
      for (int cyc = 0; cyc < 2200; cyc++) begin
        @(negedge clk);
        // Mid-frame input changes must be ignored until the next frame start.
        if ($urandom_range(0, 99) < 3) solid_color = 16'($urandom);
        if (p >= 2) pattern_sel = ($urandom_range(0, 99) == 0) ? 2'($urandom) : pats[p];
        if (p >= 4 && $urandom_range(0, 199) == 0) enable = ~enable;
      end
      @(negedge clk);
      if (p < 5) do_reset(1'b1);
    end
    enable = 1'b0;
    repeat (2000) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cam_dvp_tx.md
CAM_DVP_TX -- requirements
Module: cam_dvp_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line; must be a multiple of 8.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 144: byte slots with href low after each line's active bytes.
REQ-004 SHALL have parameters VSYNC_LINES, V_BACK and V_FRONT, defaults 3, 17 and 10: line counts for the sync, back-porch and front-porch periods.
REQ-005 SHALL have these ports; one clock; reset is asynchronous and active-high:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- enable  in  1  run frames continuously while high
- pattern_sel  in  2  pattern: 0 bars, 1 ramp, 2 solid, 3 byte counter
- solid_color  in  16  RGB565 colour for pattern 2
- cam_pclk  out  1  pixel clock
- cam_vsync  out  1  frame sync, active high
- cam_href  out  1  line valid
- cam_data  out  8  pixel byte
- frame_done  out  1  one-clk pulse at end of frame
- busy  out  1  high while a frame is in progress

Function
REQ-006 SHALL divide time into byte slots of 2 clk cycles each: cam_pclk is 0 in the first cycle and 1 in the second.
REQ-007 SHALL update cam_data, cam_href and cam_vsync only on the clk edge that drives cam_pclk low, so all three are stable at the cam_pclk rising edge.
REQ-008 SHALL toggle cam_pclk in every state except while reset is asserted.
REQ-009 SHALL set line time to L = 2*H_ACTIVE + H_BLANK slots.
REQ-010 SHALL implement the states IDLE, VSYNC, VBACK, ACTIVE and VFRONT.
REQ-011 IDLE: when enable=1 at a slot boundary, SHALL go to VSYNC and latch pattern_sel and solid_color for the whole frame.
REQ-012 VSYNC: SHALL hold cam_vsync=1 and cam_href=0 for VSYNC_LINES*L slots, then go to VBACK.
REQ-013 VBACK: SHALL hold cam_vsync=0 and cam_href=0 for V_BACK*L slots, then go to ACTIVE.
REQ-014 ACTIVE: SHALL output V_ACTIVE lines; each line is 2*H_ACTIVE slots with href=1, then H_BLANK slots with href=0. After the last line it SHALL go to VFRONT.
REQ-015 VFRONT: SHALL run V_FRONT*L slots with href=0, then pulse frame_done for 1 clk in the frame's final cycle.
REQ-016 After VFRONT: if enable=1 the next slot SHALL begin VSYNC with no gap; otherwise the block SHALL go to IDLE.
REQ-017 enable deasserted mid-frame SHALL NOT abort the frame; pattern_sel and solid_color changes mid-frame SHALL be ignored.
REQ-018 Each pixel SHALL be RGB565 sent high byte first; x is the pixel index 0..H_ACTIVE-1 and resets on every line.
REQ-019 Pattern 0 SHALL show 8 bars of width H_ACTIVE/8: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000, selected by a bar counter (no divider).
REQ-020 Pattern 1 SHALL send pixel value x[15:0], zero-extended.
REQ-021 Pattern 2 SHALL send the latched solid_color for every pixel.
REQ-022 Pattern 3 SHALL send byte n[7:0], where n counts active bytes from 0 at frame start, increments on every href=1 slot, wraps 0xFF->0x00 and is not reset per line.
REQ-023 cam_data SHALL be 0x00 whenever href=0.
REQ-024 busy SHALL be 1 in every state except IDLE.

Reset
REQ-025 reset SHALL asynchronously force IDLE, clear all counters and drive every output to 0 (including cam_pclk).
REQ-026 Release of reset SHALL start cam_pclk with a low phase on the first clk edge; reset asserted mid-frame SHALL abort the frame immediately.

Verification
All scenarios use H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, giving L=20 slots = 40 clk and a frame of 140 slots = 280 clk.
REQ-027 Pattern 3, enable held high: vsync high for 40 clk; href pulses of 16 slots ×4 lines; bytes 0x00..0x3F sampled at pclk rises; frame_done at clk 280 after vsync rise; next vsync rises in the following slot.
REQ-028 Pattern 0 with H_ACTIVE=16: each line yields byte pairs FF,FF ×2, FF,E0 ×2 ... 00,00 ×2.
REQ-029 Pattern 2, solid_color=0xABCD, changed to 0x1234 mid-frame: the whole frame is AB,CD; the next frame is 12,34.
REQ-030 enable dropped during ACTIVE: the frame completes, frame_done pulses, busy falls and vsync stays 0 afterwards; pclk keeps toggling.
REQ-031 reset asserted during line 2: all outputs are 0 asynchronously; on release with enable=1 a fresh frame starts and pattern 3 restarts at 0x00.
REQ-032 Pattern 3 with H_ACTIVE=64 and V_ACTIVE=4: byte sequence wraps 0xFF->0x00 at byte 256 with no glitch on href.
